// File: rtl/lshift_seq16.sv
// lshift_seq16: sequential signed left shift, one bit per clock, valid/ready handshake (LSHIFT_SAT_EN selects saturation on overflow)
module lshift_seq16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [3:0]  sh,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] dataout,
  output logic        ovf,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] data_q, data_d, dataout_q, dataout_d, shifted, result;
  logic [3:0] count_q, count_d;
  logic sign_q, sign_d, acc_q, acc_d, ovf_q, ovf_d, acc_next;
  // next-state, shift datapath and result capture at DONE entry
  always_comb begin
    shifted   = {data_q[14:0], 1'b0};
    acc_next  = acc_q | (data_q[15] ^ data_q[14]);
`ifdef LSHIFT_SAT_EN
    result    = acc_next ? (sign_q ? 16'h8000 : 16'h7FFF) : shifted;
`else
    result    = shifted;
`endif
    state_d   = state_q;
    data_d    = data_q;
    count_d   = count_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    dataout_d = dataout_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        data_d  = a;
        count_d = sh;
        sign_d  = a[15];
        acc_d   = 1'b0;
        if (sh == 4'd0) begin
          state_d   = DONE;
          dataout_d = a;
          ovf_d     = 1'b0;
        end else state_d = SHIFT;
      end
      SHIFT: begin
        data_d  = shifted;
        acc_d   = acc_next;
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d   = DONE;
          dataout_d = result;
          ovf_d     = acc_next;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      count_q   <= '0;
      sign_q    <= 1'b0;
      acc_q     <= 1'b0;
      dataout_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      count_q   <= count_d;
      sign_q    <= sign_d;
      acc_q     <= acc_d;
      dataout_q <= dataout_d;
      ovf_q     <= ovf_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign dataout   = dataout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_lshift_seq16.sv
// tb_lshift_seq16: directed checks of lshift_seq16 latency, results, backpressure and reset
module tb_lshift_seq16;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [3:0] sh = '0;
  logic in_ready, out_valid, ovf, busy;
  logic [15:0] dataout;
  int total = 0, bad = 0;
  lshift_seq16 dut (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .sh(sh),
                    .out_valid(out_valid), .out_ready(out_ready), .dataout(dataout), .ovf(ovf), .busy(busy));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [15:0] av, input logic [3:0] sv);
    @(negedge clk);
    in_valid = 1'b1; a = av; sh = sv;
    @(posedge clk);
    #1 in_valid = 1'b0; a = 16'hDEAD; sh = 4'h7;
  endtask
  task automatic wait_res(input string tag, input int lat, input logic [15:0] d, input logic o);
    int n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 40) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_data"}, {16'd0, dataout}, {16'd0, d});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, o});
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
  endtask
  task automatic release_out(input string tag, input logic [15:0] d);
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h1111; sh = 4'd0;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_ov"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle_rdy"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_hold"}, {16'd0, dataout}, {16'd0, d});
    in_valid = 1'b0;
  endtask
  initial begin
    #1;
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", {16'd0, dataout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk); reset = 1'b0;
    send(16'h0003, 4'd4);  wait_res("norm", 4, 16'h0030, 1'b0);  release_out("norm", 16'h0030);
    send(16'h4000, 4'd1);
`ifdef LSHIFT_SAT_EN
    wait_res("ovf", 1, 16'h7FFF, 1'b1); release_out("ovf", 16'h7FFF);
`else
    wait_res("ovf", 1, 16'h8000, 1'b1); release_out("ovf", 16'h8000);
`endif
    send(16'h8001, 4'd0);  wait_res("zero", 0, 16'h8001, 1'b0);  release_out("zero", 16'h8001);
    send(16'hC000, 4'd2);
`ifdef LSHIFT_SAT_EN
    wait_res("neg", 2, 16'h8000, 1'b1); release_out("neg", 16'h8000);
`else
    wait_res("neg", 2, 16'h0000, 1'b1); release_out("neg", 16'h0000);
`endif
    send(16'h4000, 4'd3);
`ifdef LSHIFT_SAT_EN
    wait_res("sticky", 3, 16'h7FFF, 1'b1); release_out("sticky", 16'h7FFF);
`else
    wait_res("sticky", 3, 16'h0000, 1'b1); release_out("sticky", 16'h0000);
`endif
    send(16'hFFFF, 4'd15); wait_res("max", 15, 16'h8000, 1'b0);  release_out("max", 16'h8000);
    send(16'h0123, 4'd3);  wait_res("bp", 3, 16'h0918, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1; a = 16'h0005; sh = 4'd1;
      @(negedge clk);
      chk("bp_ov", {31'd0, out_valid}, 32'd1);
      chk("bp_data", {16'd0, dataout}, 32'h0918);
      chk("bp_rdy", {31'd0, in_ready}, 32'd0);
    end
    release_out("bp", 16'h0918);
    @(negedge clk);
    chk("bp_noacc", {31'd0, busy}, 32'd0);
    send(16'h0001, 4'd8);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_data", {16'd0, dataout}, 32'd0);
    chk("mid_ov", {31'd0, out_valid}, 32'd0);
    chk("mid_rdy", {31'd0, in_ready}, 32'd1);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); reset = 1'b0;
    begin
      int seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (out_valid === 1'b1) seen++;
      end
      chk("mid_nores", seen, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
